// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: one single-port RAM shared by instruction fetch and load/store.
// Ports: clk_i/rst_i; if_* fetch side; dm_* data side; ram_* RAM side;
//        flush_i cancels a pending fetch; stall_*_o hold the pipeline;
//        bus_err_o pulses with the ack of a timed-out access.
module mem_bus_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        flush_i,
  input  logic        dm_req_i,
  input  logic        dm_wr_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_ready_i,
  output logic        stall_if_o,
  output logic        stall_dm_o,
  output logic        bus_err_o
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic          ram_ce_q, ram_ce_d;
  logic          ram_we_q, ram_we_d;
  logic [31:0]   ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          bus_err_q, bus_err_d;
  logic          flush_seen_q, flush_seen_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic if_live;
  logic if_starved;
  logic tmo_hit;

  assign if_live    = if_req_i & ~flush_i;
  assign if_starved = if_live && (wait_cnt_q == WW'(MAX_WAIT));
  assign tmo_hit    = (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    ram_ce_d     = ram_ce_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    bus_err_d    = 1'b0;
    flush_seen_d = flush_seen_q;
    wait_cnt_d   = wait_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;

    unique case (state_q)
      IDLE: begin
        flush_seen_d = 1'b0;
        if (!if_req_i) wait_cnt_d = '0;
        if (dm_req_i && !if_starved) begin
          state_d     = DM_BUSY;
          ram_ce_d    = 1'b1;
          ram_we_d    = dm_wr_i;
          ram_addr_d  = dm_addr_i;
          ram_wdata_d = dm_wdata_i;
          if (if_live && wait_cnt_q != WW'(MAX_WAIT))
            wait_cnt_d = wait_cnt_q + WW'(1);
        end else if (if_live) begin
          state_d    = IF_BUSY;
          ram_ce_d   = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = if_addr_i;
          wait_cnt_d = '0;
        end
      end

      IF_BUSY, DM_BUSY: begin
        if (flush_i) flush_seen_d = 1'b1;
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        // ready beats a simultaneous timeout
        if (ram_ready_i || tmo_hit) begin
          state_d   = DONE;
          ram_ce_d  = 1'b0;
          ram_we_d  = 1'b0;
          tmo_cnt_d = '0;
          bus_err_d = ~ram_ready_i;
          if (state_q == IF_BUSY) begin
            if_rdata_d = ram_ready_i ? ram_rdata_i : '0;
            if_ack_d   = ~(flush_seen_q | flush_i);
          end else begin
            dm_ack_d = 1'b1;
            // a completed store leaves load data untouched
            if (!ram_we_q || !ram_ready_i)
              dm_rdata_d = ram_ready_i ? ram_rdata_i : '0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      bus_err_q    <= 1'b0;
      flush_seen_q <= 1'b0;
      wait_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ram_ce_q     <= ram_ce_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      bus_err_q    <= bus_err_d;
      flush_seen_q <= flush_seen_d;
      wait_cnt_q   <= wait_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // a flush arriving in the DONE cycle still hides the fetch ack
  assign if_ack_o    = if_ack_q & ~flush_i;
  assign dm_ack_o    = dm_ack_q;
  assign bus_err_o   = bus_err_q & (dm_ack_q | if_ack_o);
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign ram_ce_o    = ram_ce_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign stall_if_o  = if_req_i & ~if_ack_o & ~flush_i;
  assign stall_dm_o  = dm_req_i & ~dm_ack_o;

endmodule
